// File: rtl/i2c_txn_arbiter.sv
// ============================================================================
//  i2c_txn_arbiter
//  Round-robin arbiter/sequencer sharing one single-byte I2C master engine.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module i2c_txn_arbiter #(
   parameter int NREQ      = 4,
   parameter int NEWD_HOLD = 24,
   parameter int TIMEOUT   = 65535
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ-1:0]      req_wr,
   input  logic [7*NREQ-1:0]    req_addr,
   input  logic [8*NREQ-1:0]    req_wdata,
   output logic [NREQ-1:0]      gnt,
   output logic [NREQ-1:0]      rsp_valid,
   output logic                 rsp_err,
   output logic [7:0]           rsp_rdata,
   output logic                 busy,
   output logic                 m_newd,
   output logic                 m_wr,
   output logic [6:0]           m_addr,
   output logic [7:0]           m_wdata,
   input  logic                 m_done,
   input  logic [7:0]           m_rdata
);

   localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int HOLD_W = $clog2(NEWD_HOLD + 1);
   localparam int TO_W   = $clog2(TIMEOUT + 1);

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(NEWD_HOLD);
   localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);
   localparam logic [IDX_W-1:0]  LAST_RST  = IDX_W'(NREQ - 1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LAUNCH    = 3'd1,
      ST_WAIT_DONE = 3'd2,
      ST_RESP      = 3'd3,
      ST_WAIT_CLR  = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    win_q, win_d;
   logic [IDX_W-1:0]    last_q, last_d;
   logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
   logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
   logic [NREQ-1:0]     gnt_q, gnt_d;
   logic [NREQ-1:0]     rsp_valid_q, rsp_valid_d;
   logic                rsp_err_q, rsp_err_d;
   logic [7:0]          rsp_rdata_q, rsp_rdata_d;
   logic                m_newd_q, m_newd_d;
   logic                m_wr_q, m_wr_d;
   logic [6:0]          m_addr_q, m_addr_d;
   logic [7:0]          m_wdata_q, m_wdata_d;
   logic                m_done_q, m_done_d;

   logic [6:0]          addr_arr  [NREQ];
   logic [7:0]          wdata_arr [NREQ];
   logic                arb_found;
   logic [IDX_W-1:0]    arb_idx;
   logic [IDX_W-1:0]    cand_idx;

   genvar g;
   generate
      for (g = 0; g < NREQ; g++) begin : g_unpack
         assign addr_arr[g]  = req_addr[7*g +: 7];
         assign wdata_arr[g] = req_wdata[8*g +: 8];
      end
   endgenerate

   // Rotating search: first requester above the previous winner, wrapping.
   always_comb begin
      arb_found = 1'b0;
      arb_idx   = last_q;
      cand_idx  = '0;
      for (int i = 1; i <= NREQ; i++) begin
         cand_idx = IDX_W'((int'(last_q) + i) % NREQ);
         if (!arb_found && req[cand_idx]) begin
            arb_found = 1'b1;
            arb_idx   = cand_idx;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      win_d       = win_q;
      last_d      = last_q;
      hold_cnt_d  = hold_cnt_q;
      to_cnt_d    = to_cnt_q;
      gnt_d       = gnt_q;
      rsp_valid_d = '0;
      rsp_err_d   = rsp_err_q;
      rsp_rdata_d = rsp_rdata_q;
      m_newd_d    = 1'b0;
      m_wr_d      = m_wr_q;
      m_addr_d    = m_addr_q;
      m_wdata_d   = m_wdata_q;
      m_done_d    = m_done;

      case (state_q)
         ST_IDLE: begin
            if (arb_found) begin
               win_d      = arb_idx;
               gnt_d      = {{(NREQ-1){1'b0}}, 1'b1} << arb_idx;
               m_wr_d     = req_wr[arb_idx];
               m_addr_d   = addr_arr[arb_idx];
               m_wdata_d  = wdata_arr[arb_idx];
               hold_cnt_d = '0;
               state_d    = ST_LAUNCH;
            end
         end

         ST_LAUNCH: begin
            if (hold_cnt_q == HOLD_LAST) begin
               to_cnt_d = '0;
               state_d  = ST_WAIT_DONE;
            end else begin
               m_newd_d   = 1'b1;
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end

         // done is registered once before use, so it takes priority over
         // the timeout when both land in the same cycle.
         ST_WAIT_DONE: begin
            if (m_done_q) begin
               rsp_err_d   = 1'b0;
               rsp_rdata_d = m_wr_q ? 8'h00 : m_rdata;
               rsp_valid_d = gnt_q;
               state_d     = ST_RESP;
            end else if (to_cnt_q == TO_LAST) begin
               rsp_err_d   = 1'b1;
               rsp_rdata_d = 8'h00;
               rsp_valid_d = gnt_q;
               state_d     = ST_RESP;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end

         ST_RESP: begin
            gnt_d       = '0;
            last_d      = win_q;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = 8'h00;
            state_d     = rsp_err_q ? ST_IDLE : ST_WAIT_CLR;
         end

         ST_WAIT_CLR: begin
            if (!m_done) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         win_q       <= '0;
         last_q      <= LAST_RST;
         hold_cnt_q  <= '0;
         to_cnt_q    <= '0;
         gnt_q       <= '0;
         rsp_valid_q <= '0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= 8'h00;
         m_newd_q    <= 1'b0;
         m_wr_q      <= 1'b0;
         m_addr_q    <= 7'h00;
         m_wdata_q   <= 8'h00;
         m_done_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         win_q       <= win_d;
         last_q      <= last_d;
         hold_cnt_q  <= hold_cnt_d;
         to_cnt_q    <= to_cnt_d;
         gnt_q       <= gnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
         m_newd_q    <= m_newd_d;
         m_wr_q      <= m_wr_d;
         m_addr_q    <= m_addr_d;
         m_wdata_q   <= m_wdata_d;
         m_done_q    <= m_done_d;
      end
   end

   assign gnt       = gnt_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;
   assign busy      = (state_q != ST_IDLE);
   assign m_newd    = m_newd_q;
   assign m_wr      = m_wr_q;
   assign m_addr    = m_addr_q;
   assign m_wdata   = m_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_i2c_txn_arbiter.sv
// ============================================================================
//  tb_i2c_txn_arbiter
//  Directed self-checking bench for i2c_txn_arbiter (NREQ=4, hold 24, timeout 100).
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_i2c_txn_arbiter;

   localparam int NREQ = 4;
   localparam int HOLD = 24;
   localparam int TO   = 100;

   logic              clk;
   logic              rst;
   logic [NREQ-1:0]   req;
   logic [NREQ-1:0]   req_wr;
   logic [7*NREQ-1:0] req_addr;
   logic [8*NREQ-1:0] req_wdata;
   logic [NREQ-1:0]   gnt;
   logic [NREQ-1:0]   rsp_valid;
   logic              rsp_err;
   logic [7:0]        rsp_rdata;
   logic              busy;
   logic              m_newd;
   logic              m_wr;
   logic [6:0]        m_addr;
   logic [7:0]        m_wdata;
   logic              m_done;
   logic [7:0]        m_rdata;

   int checks = 0;
   int errors = 0;

   i2c_txn_arbiter #(.NREQ(NREQ), .NEWD_HOLD(HOLD), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .req(req), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
      .gnt(gnt), .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
      .busy(busy), .m_newd(m_newd), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_done(m_done), .m_rdata(m_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_fields(input int k, input bit wr, input logic [6:0] a, input logic [7:0] d);
      req_wr[k]            = wr;
      req_addr[7*k +: 7]   = a;
      req_wdata[8*k +: 8]  = d;
   endtask

   // Waits for a grant, checks it, then measures the m_newd pulse and
   // command stability; returns one cycle after m_newd falls.
   task automatic launch_phase(input int k, input bit wr, input logic [6:0] a,
                               input logic [7:0] d, output int lat);
      logic [3:0] e;
      int hi;
      bit bad;
      e = 4'b0001 << k;
      lat = 0;
      while (gnt == 4'b0000 && lat < 200) begin
         tick();
         lat++;
      end
      checks++;
      if (gnt !== e) begin
         errors++;
         $display("FAIL grant_req%0d: gnt=%b expected %b", k, gnt, e);
      end
      checks++;
      if (m_newd !== 1'b0) begin
         errors++;
         $display("FAIL newd_at_grant_req%0d: m_newd=%b expected 0", k, m_newd);
      end
      hi = 0;
      bad = 1'b0;
      tick();
      while (m_newd === 1'b1 && hi < 100) begin
         hi++;
         if (m_wr !== wr || m_addr !== a || m_wdata !== d) bad = 1'b1;
         tick();
      end
      checks++;
      if (hi != HOLD) begin
         errors++;
         $display("FAIL newd_width_req%0d: high %0d cycles expected %0d", k, hi, HOLD);
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL cmd_in_launch_req%0d: wr=%b addr=%h wdata=%h expected %b %h %h",
                  k, m_wr, m_addr, m_wdata, wr, a, d);
      end
   endtask

   // Master answers 3 cycles into WAIT_DONE and holds done for 'hold' cycles.
   task automatic finish_ok(input int k, input bit wr, input logic [6:0] a, input logic [7:0] d,
                            input logic [7:0] rd, input int hold, input bit keep);
      logic [3:0] e;
      logic [7:0] erd;
      e = 4'b0001 << k;
      erd = wr ? 8'h00 : rd;
      repeat (3) tick();
      m_done  = 1'b1;
      m_rdata = rd;
      tick();
      checks++;
      if (rsp_valid !== 4'b0000) begin
         errors++;
         $display("FAIL rsp_early_req%0d: rsp_valid=%b expected 0000", k, rsp_valid);
      end
      tick();
      checks++;
      if (rsp_valid !== e || rsp_err !== 1'b0 || rsp_rdata !== erd || gnt !== e) begin
         errors++;
         $display("FAIL rsp_req%0d: valid=%b err=%b rdata=%h gnt=%b expected %b 0 %h %b",
                  k, rsp_valid, rsp_err, rsp_rdata, gnt, e, erd, e);
      end
      checks++;
      if (m_wr !== wr || m_addr !== a || m_wdata !== d) begin
         errors++;
         $display("FAIL cmd_at_resp_req%0d: wr=%b addr=%h wdata=%h expected %b %h %h",
                  k, m_wr, m_addr, m_wdata, wr, a, d);
      end
      if (!keep) req[k] = 1'b0;
      for (int i = 2; i < hold; i++) begin
         tick();
         checks++;
         if (gnt !== 4'b0000 || rsp_valid !== 4'b0000) begin
            errors++;
            $display("FAIL quiet_while_done_req%0d: gnt=%b rsp_valid=%b expected 0000 0000",
                     k, gnt, rsp_valid);
         end
      end
      m_done  = 1'b0;
      m_rdata = 8'h00;
   endtask

   task automatic check_all_zero(input string name);
      checks++;
      if ({gnt, rsp_valid, rsp_err, rsp_rdata, busy, m_newd, m_wr, m_addr, m_wdata} !== '0) begin
         errors++;
         $display("FAIL %s: gnt=%b vld=%b err=%b rd=%h busy=%b newd=%b wr=%b addr=%h wd=%h expected all 0",
                  name, gnt, rsp_valid, rsp_err, rsp_rdata, busy, m_newd, m_wr, m_addr, m_wdata);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) tick();
      check_all_zero("reset_outputs");
      rst = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset: busy=%b expected 0", busy);
      end
   endtask

   task automatic test_rr_priority();
      int seq [5] = '{0, 1, 2, 3, 0};
      int lat;
      for (int k = 0; k < NREQ; k++) set_fields(k, 1'b0, 7'(7'h10 + k), 8'(8'h80 + k));
      req = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         launch_phase(seq[n], 1'b0, 7'(7'h10 + seq[n]), 8'(8'h80 + seq[n]), lat);
         checks++;
         if (lat != ((n == 0) ? 1 : 2)) begin
            errors++;
            $display("FAIL rr_grant_latency_%0d: %0d cycles expected %0d", n, lat, (n == 0) ? 1 : 2);
         end
         finish_ok(seq[n], 1'b0, 7'(7'h10 + seq[n]), 8'(8'h80 + seq[n]), 8'(8'h40 + n), 4, 1'b1);
      end
      req = 4'b0000;
      repeat (3) tick();
   endtask

   task automatic test_read();
      int lat;
      set_fields(2, 1'b0, 7'h50, 8'h00);
      set_fields(0, 1'b0, 7'h11, 8'h00);
      req = 4'b0101;
      launch_phase(2, 1'b0, 7'h50, 8'h00, lat);
      checks++;
      if (lat != 1) begin
         errors++;
         $display("FAIL read_grant_latency: %0d cycles expected 1", lat);
      end
      finish_ok(2, 1'b0, 7'h50, 8'h00, 8'hA5, 30, 1'b0);
      launch_phase(0, 1'b0, 7'h11, 8'h00, lat);
      checks++;
      if (lat != 2) begin
         errors++;
         $display("FAIL grant_after_done_fall: %0d cycles expected 2", lat);
      end
      finish_ok(0, 1'b0, 7'h11, 8'h00, 8'h3E, 4, 1'b0);
      repeat (3) tick();
   endtask

   task automatic test_write();
      int lat;
      set_fields(1, 1'b1, 7'h22, 8'h3C);
      req = 4'b0010;
      launch_phase(1, 1'b1, 7'h22, 8'h3C, lat);
      finish_ok(1, 1'b1, 7'h22, 8'h3C, 8'hFF, 4, 1'b0);
      repeat (3) tick();
   endtask

   task automatic test_timeout();
      int lat;
      int n;
      set_fields(3, 1'b0, 7'h33, 8'h00);
      set_fields(0, 1'b0, 7'h44, 8'h00);
      req = 4'b1001;
      launch_phase(3, 1'b0, 7'h33, 8'h00, lat);
      m_rdata = 8'hEE;
      n = 0;
      while (rsp_valid == 4'b0000 && n < 300) begin
         tick();
         n++;
      end
      checks++;
      if (n != TO) begin
         errors++;
         $display("FAIL timeout_delay: rsp after %0d cycles expected %0d", n, TO);
      end
      checks++;
      if (rsp_valid !== 4'b1000 || rsp_err !== 1'b1 || rsp_rdata !== 8'h00) begin
         errors++;
         $display("FAIL timeout_rsp: valid=%b err=%b rdata=%h expected 1000 1 00",
                  rsp_valid, rsp_err, rsp_rdata);
      end
      req[3] = 1'b0;
      m_rdata = 8'h00;
      tick();
      checks++;
      if (busy !== 1'b0 || gnt !== 4'b0000) begin
         errors++;
         $display("FAIL idle_after_error: busy=%b gnt=%b expected 0 0000", busy, gnt);
      end
      tick();
      checks++;
      if (gnt !== 4'b0001) begin
         errors++;
         $display("FAIL pending_after_error: gnt=%b expected 0001", gnt);
      end
      launch_phase(0, 1'b0, 7'h44, 8'h00, lat);
      finish_ok(0, 1'b0, 7'h44, 8'h00, 8'h77, 4, 1'b0);
      repeat (3) tick();
   endtask

   task automatic test_done_timeout_tie();
      int lat;
      set_fields(2, 1'b0, 7'h2A, 8'h00);
      req = 4'b0100;
      launch_phase(2, 1'b0, 7'h2A, 8'h00, lat);
      repeat (TO - 2) tick();
      m_done  = 1'b1;
      m_rdata = 8'h5A;
      tick();
      checks++;
      if (rsp_valid !== 4'b0000) begin
         errors++;
         $display("FAIL tie_rsp_early: rsp_valid=%b expected 0000", rsp_valid);
      end
      tick();
      checks++;
      if (rsp_valid !== 4'b0100 || rsp_err !== 1'b0 || rsp_rdata !== 8'h5A) begin
         errors++;
         $display("FAIL tie_rsp: valid=%b err=%b rdata=%h expected 0100 0 5a",
                  rsp_valid, rsp_err, rsp_rdata);
      end
      req = 4'b0000;
      repeat (2) tick();
      m_done  = 1'b0;
      m_rdata = 8'h00;
      repeat (3) tick();

      // done one cycle too late loses to the timeout
      set_fields(3, 1'b0, 7'h3B, 8'h00);
      req = 4'b1000;
      launch_phase(3, 1'b0, 7'h3B, 8'h00, lat);
      repeat (TO - 1) tick();
      m_done  = 1'b1;
      m_rdata = 8'h6B;
      tick();
      checks++;
      if (rsp_valid !== 4'b1000 || rsp_err !== 1'b1 || rsp_rdata !== 8'h00) begin
         errors++;
         $display("FAIL late_done_rsp: valid=%b err=%b rdata=%h expected 1000 1 00",
                  rsp_valid, rsp_err, rsp_rdata);
      end
      req = 4'b0000;
      tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL late_done_idle: busy=%b expected 0", busy);
      end
      m_done  = 1'b0;
      m_rdata = 8'h00;
      repeat (3) tick();
   endtask

   task automatic test_reset_mid_txn();
      int lat;
      set_fields(1, 1'b1, 7'h5C, 8'hC3);
      req = 4'b0010;
      launch_phase(1, 1'b1, 7'h5C, 8'hC3, lat);
      repeat (10) tick();
      #2;
      rst = 1'b1;
      #1;
      check_all_zero("reset_in_wait_done");
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (rsp_valid !== 4'b0000) begin
            errors++;
            $display("FAIL rsp_during_reset: rsp_valid=%b expected 0000", rsp_valid);
         end
      end
      req = 4'b1000;
      rst = 1'b0;
      tick();
      checks++;
      if (gnt !== 4'b1000) begin
         errors++;
         $display("FAIL grant_after_reset_release: gnt=%b expected 1000", gnt);
      end
      repeat (5) tick();
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (m_newd !== 1'b0) begin
         errors++;
         $display("FAIL newd_reset_in_launch: m_newd=%b expected 0", m_newd);
      end
      req = 4'b0000;
      tick();
   endtask

   initial begin
      rst       = 1'b1;
      req       = '0;
      req_wr    = '0;
      req_addr  = '0;
      req_wdata = '0;
      m_done    = 1'b0;
      m_rdata   = 8'h00;
      test_reset();
      test_rr_priority();
      test_read();
      test_write();
      test_timeout();
      test_done_timeout_tie();
      test_reset_mid_txn();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
